// File: rtl/maxpool2d_stream_pkg.sv
// Shared accelerator definitions: default pixel geometry and the pooling-stage state encoding.
package maxpool2d_stream_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_WIDTH  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

endpackage

// File: rtl/maxpool_linebuf.sv
// Single-port line buffer holding one horizontal pair-max per output column.
module maxpool_linebuf #(
  parameter int DATA_WIDTH = maxpool2d_stream_pkg::DATA_WIDTH,
  parameter int DEPTH      = maxpool2d_stream_pkg::MAX_WIDTH / 2,
  parameter int ADDR_W     = 7
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Read data only changes on a read, so it holds across input gaps.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        mem[i_addr] <= i_wdata;
      end else begin
        rdata_reg <= mem[i_addr];
      end
    end
  end

  assign o_rdata = rdata_reg;

endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 / stride-2 max pooling over channel-major raster input, one line buffer of pair maxima.
module maxpool2d_stream #(
  parameter int DATA_WIDTH = maxpool2d_stream_pkg::DATA_WIDTH,
  parameter int MAX_WIDTH  = maxpool2d_stream_pkg::MAX_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_max_width,
  input  logic [7:0]            i_max_height,
  input  logic [9:0]            i_max_ch,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done
);
  import maxpool2d_stream_pkg::*;

  localparam int DEPTH  = MAX_WIDTH / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  pool_state_t state_reg, state_next;

  logic [7:0] w_reg, h_reg;
  logic [9:0] c_reg;
  logic [7:0] col_reg, row_reg;
  logic [9:0] ch_reg;

  logic signed [DATA_WIDTH-1:0] pair_reg;
  logic signed [DATA_WIDTH-1:0] o_data_reg;
  logic                         o_valid_reg;
  logic                         o_done_reg;

  logic                         accept;
  logic                         col_last, row_last, ch_last, pix_last;
  logic                         geom_zero;
  logic signed [DATA_WIDTH-1:0] pixel;
  logic signed [DATA_WIDTH-1:0] lb_rdata;
  logic [DATA_WIDTH-1:0]        lb_rdata_raw;
  logic                         lb_en, lb_we;
  logic [ADDR_W-1:0]            lb_addr;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] pool_max;

  assign accept    = (state_reg == RUN) && i_valid;
  assign pixel     = $signed(i_data);
  assign col_last  = (col_reg == w_reg - 8'd1);
  assign row_last  = (row_reg == h_reg - 8'd1);
  assign ch_last   = (ch_reg == c_reg - 10'd1);
  assign pix_last  = col_last && row_last && ch_last;
  assign geom_zero = (i_max_width == 8'd0) || (i_max_height == 8'd0) || (i_max_ch == 10'd0);

  // Even column reads the pair-max stored by the previous (even) row; odd column of an even row writes it.
  assign lb_en    = accept && (!col_reg[0] || !row_reg[0]);
  assign lb_we    = accept && col_reg[0] && !row_reg[0];
  assign lb_addr  = ADDR_W'(col_reg >> 1);
  assign pair_max = smax(pair_reg, pixel);
  assign lb_rdata = $signed(lb_rdata_raw);
  assign pool_max = smax(lb_rdata, pair_max);

  maxpool_linebuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_linebuf (
    .i_clk   (i_clk),
    .i_en    (lb_en),
    .i_we    (lb_we),
    .i_addr  (lb_addr),
    .i_wdata (pair_max),
    .o_rdata (lb_rdata_raw)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = geom_zero ? DONE : RUN;
      RUN:     if (accept && pix_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= IDLE;
      w_reg       <= '0;
      h_reg       <= '0;
      c_reg       <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      ch_reg      <= '0;
      pair_reg    <= '0;
      o_data_reg  <= '0;
      o_valid_reg <= 1'b0;
      o_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      o_valid_reg <= 1'b0;
      o_done_reg  <= (state_next == DONE);

      if (state_reg == IDLE && i_start) begin
        w_reg   <= i_max_width;
        h_reg   <= i_max_height;
        c_reg   <= i_max_ch;
        col_reg <= '0;
        row_reg <= '0;
        ch_reg  <= '0;
      end

      if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          if (row_last) begin
            row_reg <= '0;
            ch_reg  <= ch_reg + 10'd1;
          end else begin
            row_reg <= row_reg + 8'd1;
          end
        end else begin
          col_reg <= col_reg + 8'd1;
        end

        if (!col_reg[0]) begin
          pair_reg <= pixel;
        end else if (row_reg[0]) begin
          o_data_reg  <= pool_max;
          o_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign o_data  = o_data_reg;
  assign o_valid = o_valid_reg;
  assign o_busy  = (state_reg == RUN);
  assign o_done  = o_done_reg;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Randomized scoreboard bench for maxpool2d_stream against a block-wise max reference.
module tb_maxpool2d_stream;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_max_width;
  logic [7:0]  i_max_height;
  logic [9:0]  i_max_ch;
  logic [15:0] i_data;
  logic        i_valid;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int pix[$];
  bit last_has_out = 1'b0;
  int mon_got;
  int mon_exp;

  maxpool2d_stream dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (i_start),
    .i_max_width  (i_max_width),
    .i_max_height (i_max_height),
    .i_max_ch     (i_max_ch),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Reference: each pooled output is the max of a full 2x2 block; the block appears once its
  // bottom-right pixel has been streamed (index < n). Partial blocks at odd edges never appear.
  task automatic model(input int w, input int h, input int c, input int n);
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int q = 0; q < w / 2; q++) begin
          int p00, p01, p10, p11, m;
          p00 = ch * w * h + 2 * r * w + 2 * q;
          p01 = p00 + 1;
          p10 = p00 + w;
          p11 = p10 + 1;
          if (p11 < n) begin
            m = pix[p00];
            if (pix[p01] > m) m = pix[p01];
            if (pix[p10] > m) m = pix[p10];
            if (pix[p11] > m) m = pix[p11];
            exp_q.push_back(m);
          end
        end
  endtask

  task automatic fill_ramp(input int n, input int first, input int step);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(first + i * step);
  endtask

  task automatic fill_rand(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      pix.push_back(int'($signed(r)));
    end
  endtask

  // gap_mode: 0 continuous, 1 valid pattern 1-0-0, 2 random gaps of 0..3 cycles
  task automatic run_case(input string name, input int w, input int h, input int c,
                          input int gap_mode, input bit hold_start, input int n_feed);
    int total, n, gaps;
    total = w * h * c;
    n = (n_feed < 0) ? total : n_feed;
    model(w, h, c, n);
    last_has_out = (w % 2 == 0) && (h % 2 == 0) && (w > 0) && (h > 0) && (c > 0);
    $display("case %s: W=%0d H=%0d C=%0d pixels=%0d expected_outputs=%0d",
             name, w, h, c, n, exp_q.size());

    i_start      = 1'b1;
    i_max_width  = 8'(w);
    i_max_height = 8'(h);
    i_max_ch     = 10'(c);
    @(posedge clk); #1;
    i_start = 1'b0;

    if (total == 0) begin
      check({name, "_done_after_start"}, int'(o_done), 1);
      check({name, "_busy_zero"}, int'(o_busy), 0);
    end else begin
      check({name, "_busy"}, int'(o_busy), 1);
    end

    for (int i = 0; i < n; i++) begin
      int v;
      v = pix[i];
      i_valid = 1'b1;
      i_data  = v[15:0];
      if (hold_start) begin
        i_start      = 1'b1;
        i_max_width  = 8'd2;
        i_max_height = 8'd2;
        i_max_ch     = 10'd3;
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      if (i == total - 1) begin
        i_start = 1'b0;
        check({name, "_done_timing"}, int'(o_done), 1);
      end
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gaps) begin
        @(posedge clk); #1;
      end
    end
    i_start = 1'b0;

    repeat (4) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        mon_got = int'($signed(o_data));
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0d, required no output", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("out: got %0d expected %0d", mon_got, mon_exp);
          if (mon_got != mon_exp) begin
            errors++;
            $display("FAIL pooled_value: got %0d, required %0d", mon_got, mon_exp);
          end
        end
      end
      if (o_done) begin
        checks++;
        if (o_valid !== last_has_out) begin
          errors++;
          $display("FAIL done_with_last_valid: o_valid=%0d at o_done, required %0d",
                   o_valid, last_has_out);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_max_width  = '0;
    i_max_height = '0;
    i_max_ch     = '0;
    i_data       = '0;
    i_valid      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_data", int'(o_data), 0);
    check("reset_o_busy", int'(o_busy), 0);
    check("reset_o_done", int'(o_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_ramp(16, 0, 1);
    run_case("ramp4x4", 4, 4, 1, 0, 1'b0, -1);

    fill_ramp(8, -1, -1);
    run_case("negative4x2", 4, 2, 1, 0, 1'b0, -1);

    fill_ramp(30, 0, 1);
    run_case("odd5x3x2", 5, 3, 2, 0, 1'b0, -1);

    fill_ramp(16, 0, 1);
    run_case("gapped4x4", 4, 4, 1, 1, 1'b0, -1);

    fill_ramp(16, 0, 1);
    run_case("start_held", 4, 4, 1, 0, 1'b1, -1);

    fill_ramp(6, 10, 3);
    run_case("degenerate_h1", 3, 1, 2, 2, 1'b0, -1);

    pix.delete();
    run_case("zero_channels", 4, 4, 0, 0, 1'b0, -1);

    fill_ramp(16, 0, 1);
    run_case("abandoned", 4, 4, 1, 0, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", int'(o_busy), 0);
    check("midrun_reset_valid", int'(o_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pix.delete();
    pix.push_back(3);
    pix.push_back(9);
    pix.push_back(-4);
    pix.push_back(1);
    run_case("restart2x2", 2, 2, 1, 0, 1'b0, -1);

    for (int k = 0; k < 5; k++) begin
      int w, h, c;
      w = int'($urandom_range(1, 9));
      h = int'($urandom_range(1, 7));
      c = int'($urandom_range(1, 3));
      fill_rand(w * h * c);
      run_case($sformatf("random%0d", k), w, h, c, 2, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool2d_stream.md
MAXPOOL2D_STREAM -- requirements
Module: maxpool2d_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width (signed two's complement).
REQ-002 SHALL have parameter MAX_WIDTH, default 256, maximum input row width; sizes the line buffer to MAX_WIDTH/2 entries.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, one-cycle pulse that latches geometry and arms the stage.
REQ-006 SHALL have port i_max_width, input, 8, input columns W.
REQ-007 SHALL have port i_max_height, input, 8, input rows H.
REQ-008 SHALL have port i_max_ch, input, 10, channel count C.
REQ-009 SHALL have port i_data, input, DATA_WIDTH, conv2d output pixel.
REQ-010 SHALL have port i_valid, input, 1, i_data qualifier; there is no backpressure.
REQ-011 SHALL have port o_data, output, DATA_WIDTH, pooled pixel.
REQ-012 SHALL have port o_valid, output, 1, o_data qualifier, one cycle per pooled pixel.
REQ-013 SHALL have port o_busy, output, 1, high while in RUN.
REQ-014 SHALL have port o_done, output, 1, one-cycle pulse at completion.

Function
REQ-015 SHALL implement 2x2 max pooling with stride 2 on a stream ordered channel, then row, then column (raster order within each channel).
REQ-016 SHALL implement the states IDLE, RUN and DONE: IDLE to RUN on i_start; RUN to DONE when the W*H*C-th valid pixel is accepted; DONE to IDLE after one cycle.
REQ-017 SHALL latch W, H and C on i_start in IDLE; i_start SHALL be ignored in RUN and DONE.
REQ-018 SHALL ignore i_valid outside RUN.
REQ-019 SHALL maintain col, row and channel counters that advance only on accepted pixels: col wraps at W-1 and increments row; row wraps at H-1, increments channel and clears the line buffer phase.
REQ-020 SHALL, on an even column, register the pixel in a pair register and issue a line-buffer read at index col/2.
REQ-021 SHALL, on an odd column of an even row, write max(pair, pixel) to buf[col/2].
REQ-022 SHALL, on an odd column of an odd row, produce max(buf[col/2], pair, pixel) registered on o_data, with o_valid high the following cycle (latency 1).
REQ-023 SHALL use signed comparison over the full DATA_WIDTH; on ties, any equal value is correct.
REQ-024 SHALL, when W is odd, drop the last column (no write, no output); when H is odd, drop the last row (no outputs).
REQ-025 SHALL produce floor(W/2)*floor(H/2)*C outputs per run.
REQ-026 SHALL tolerate arbitrary gaps in i_valid; the pair register and the line-buffer read data SHALL hold across gaps.
REQ-027 SHALL assert o_done one cycle after the final accepted pixel, coincident with the final o_valid when that pixel produces an output.
REQ-028 SHALL treat W<2, H<2 or C=0 as degenerate: zero outputs, with o_done after W*H*C accepted pixels, or the cycle after i_start if the product is 0.

Reset
REQ-029 SHALL, when i_rst is low, force state IDLE, all counters 0, the pair register 0, o_data 0, o_valid 0, o_busy 0 and o_done 0.
REQ-030 SHALL not reset line-buffer contents; no stale entry is read, because each even row rewrites before the odd row reads.
REQ-031 SHALL, on reset mid-run, abandon the run; the next i_start begins cleanly.

Structure
REQ-032 SHALL place DATA_WIDTH, MAX_WIDTH and the state encodings (IDLE=0, RUN=1, DONE=2) in the shared accelerator package.
REQ-033 SHALL instantiate exactly one sub-module, maxpool_linebuf: a single-port, synchronous-read, DATA_WIDTH x MAX_WIDTH/2 register array.

Verification
REQ-034 SHALL cover: W=4, H=4, C=1, input 0..15 continuous -> outputs 5, 7, 13, 15, then o_done.
REQ-035 SHALL cover: W=4, H=2, C=1, input values all negative (-1..-8) -> outputs -1, -3 (signed compare).
REQ-036 SHALL cover: W=5, H=3, C=2, ramp input -> 2 outputs per channel (4 total); column 4 and row 2 ignored.
REQ-037 SHALL cover: W=4, H=4, C=1 with i_valid toggling 1-0-0-1 -> same outputs as REQ-034.
REQ-038 SHALL cover: i_rst low after 6 pixels, then restart W=2, H=2, C=1 with input 3, 9, -4, 1 -> single output 9, then o_done.
REQ-039 SHALL cover: i_start held during RUN -> geometry unchanged and output count 4.
